wb_bram_burst: RTL and testbench
================================

WB_BRAM_BURST -- requirements
Module: wb_bram_burst

Interface
REQ-001 SHALL have parameter MEM_ADR_WIDTH, default 11, log2 of the memory depth in words (2048 words).
REQ-002 SHALL have parameter DATA_BYTES, default 4, word width in bytes, power of two from 1 to 8; DW = 8*DATA_BYTES, AB = log2(DATA_BYTES).
REQ-003 SHALL have port clk, input, 1, single clock; all logic on rising edge.
REQ-004 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port cyc, input, 1, Wishbone cycle valid.
REQ-006 SHALL have port stb, input, 1, Wishbone strobe.
REQ-007 SHALL have port we, input, 1, 1 = write, 0 = read.
REQ-008 SHALL have port adr, input, 32, byte address; word index = adr[MEM_ADR_WIDTH+AB-1:AB].
REQ-009 SHALL have port sel, input, DATA_BYTES, byte-lane enables.
REQ-010 SHALL have port dat_ms, input, DW, write data.
REQ-011 SHALL have port cti, input, 3, cycle type: 000 classic, 010 incrementing burst, 111 end-of-burst.
REQ-012 SHALL have port bte, input, 2, burst type: 00 linear, 01 wrap-4, 10 wrap-8, 11 wrap-16.
REQ-013 SHALL have port dat_sm, output, DW, read data, registered.
REQ-014 SHALL have port ack, output, 1, beat acknowledge.
REQ-015 SHALL have port err, output, 1, error acknowledge (REQ-036 only; tied 0 otherwise).

Function
REQ-016 SHALL hold 2**MEM_ADR_WIDTH words of DW bits, no reset of contents.
REQ-017 SHALL write, on a cycle with cyc & stb & we, every byte lane whose sel bit is set; any sel pattern, including 0 (no-op write, still acked).
REQ-018 SHALL assert ack combinationally in the same cycle as a write beat (zero wait states), with adr taken from the bus on every write beat, burst or not.
REQ-019 SHALL return the full DW-bit word on reads irrespective of sel.
REQ-020 SHALL implement FSM IDLE / RD_FIRST / RD_BURST.
REQ-021 IDLE: on cyc & stb & ~we, register the word index into internal pointer ptr, issue memory read, go to RD_FIRST; ack low this cycle.
REQ-022 RD_FIRST: drive dat_sm = mem[ptr], ack = 1; if cti = 010, advance ptr per REQ-024, prefetch, go to RD_BURST; otherwise go to IDLE.
REQ-023 RD_BURST: while cyc & stb, ack = 1 every cycle with dat_sm = mem[ptr] (one beat per clock after the first); beat with cti = 111 or 000 is the last, then IDLE; adr ignored in RD_BURST.
REQ-024 Pointer advance: linear = ptr+1 modulo depth; wrap-N = low log2(N) bits of ptr incremented modulo N, upper bits held.
REQ-025 Read latency: first beat ack one cycle after the request; subsequent burst beats zero wait states.
REQ-026 SHALL, when stb drops with cyc high in RD_BURST, drop ack, hold ptr and dat_sm, and resume on stb return with no lost or repeated beat.
REQ-027 SHALL, when cyc drops in any state, return to IDLE on the next edge with ack low; no pending beat is delivered.
REQ-028 SHALL treat a write request arriving in RD_BURST (we = 1) as burst termination: go to IDLE, no ack that cycle; write serviced from IDLE.
REQ-029 Read and write of the same word on consecutive beats SHALL return the newly written data (write-then-read ordering preserved).
REQ-030 SHALL never assert ack while cyc = 0.

Reset
REQ-031 SHALL, on reset_n = 0, asynchronously force FSM to IDLE, ptr = 0, dat_sm = 0, ack = 0, err = 0.
REQ-032 SHALL, on reset mid-burst, abandon the burst; the first cycle after release behaves as IDLE.
REQ-033 SHALL leave memory contents unaffected by reset.

Configuration
REQ-034 Macro WB_BRAM_BURST_ERR_EN selects address range checking.
REQ-035 Without WB_BRAM_BURST_ERR_EN: adr bits above MEM_ADR_WIDTH+AB-1 ignored (aliasing); err tied 0.
REQ-036 With WB_BRAM_BURST_ERR_EN: request with any nonzero adr bit above the range, or misaligned adr (low AB bits nonzero) on a write, SHALL get err instead of ack at the same cycle ack would occur, no memory write, FSM back to IDLE.

Verification
REQ-037 Write 0xDEADBEEF at adr 0x10, sel 1111, then read 0x10 -> write ack same cycle; read ack one cycle later, dat_sm = 0xDEADBEEF.
REQ-038 Write 0x11223344 at 0x20, then 0xAABBCCDD with sel 0101 -> read returns 0x11BB33DD.
REQ-039 Linear 4-beat read burst from word 2047 (cti 010,010,010,111) -> words 2047,0,1,2 on consecutive acks, then IDLE.
REQ-040 Wrap-4 burst from word 6 -> words 6,7,4,5; stb low 2 cycles after beat 2 -> ack low, beat 3 = word 4 on resume.
REQ-041 reset_n low during beat 2 of an 8-beat burst -> ack, dat_sm = 0 immediately; next request served as classic with 1-cycle latency.
REQ-042 With WB_BRAM_BURST_ERR_EN, read at adr 0x0001_0000 (MEM_ADR_WIDTH 11) -> err = 1 one cycle after request, ack = 0; without macro -> ack with word 0 data.

Source files
------------

// File: rtl/wb_bram_burst.sv
// Wishbone B4 block-RAM slave: zero-wait writes, registered reads with incrementing/wrapping bursts.
// Define WB_BRAM_BURST_ERR_EN to answer out-of-range or misaligned requests with err instead of ack.
module wb_bram_burst #(
    parameter int MEM_ADR_WIDTH = 11,
    parameter int DATA_BYTES    = 4
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      cyc,
    input  logic                      stb,
    input  logic                      we,
    input  logic [31:0]               adr,
    input  logic [DATA_BYTES-1:0]     sel,
    input  logic [8*DATA_BYTES-1:0]   dat_ms,
    input  logic [2:0]                cti,
    input  logic [1:0]                bte,
    output logic [8*DATA_BYTES-1:0]   dat_sm,
    output logic                      ack,
    output logic                      err,
    output logic [1:0]                o_dbg_state
);
    localparam int DW    = 8 * DATA_BYTES;
    localparam int AB    = $clog2(DATA_BYTES);
    localparam int DEPTH = 1 << MEM_ADR_WIDTH;

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_RD_FIRST = 2'd1;
    localparam logic [1:0] S_RD_BURST = 2'd2;

    logic [DW-1:0]            r_mem [DEPTH];
    logic [1:0]               r_state;
    logic [1:0]               w_state_nxt;
    logic [MEM_ADR_WIDTH-1:0] r_ptr;
    logic [MEM_ADR_WIDTH-1:0] w_ptr_nxt;
    logic [MEM_ADR_WIDTH-1:0] w_ptr_inc;
    logic [MEM_ADR_WIDTH-1:0] w_wrap_mask;
    logic [MEM_ADR_WIDTH-1:0] w_idx;
    logic [DW-1:0]            r_dat;
    logic                     r_err_pend;
    logic                     w_err_pend_nxt;
    logic                     w_load;
    logic                     w_ack;
    logic                     w_err;
    logic                     w_wr_en;
    logic                     w_last;
    logic                     w_bad_rd;
    logic                     w_bad_wr;

    assign w_idx  = adr[MEM_ADR_WIDTH+AB-1:AB];
    assign w_last = (cti == 3'b111) || (cti == 3'b000);

`ifdef WB_BRAM_BURST_ERR_EN
    localparam logic [31:0] LOW_MASK = (32'd1 << AB) - 32'd1;
    logic w_hi;
    logic w_mis;
    assign w_hi     = |(adr >> (MEM_ADR_WIDTH + AB));
    assign w_mis    = |(adr & LOW_MASK);
    assign w_bad_rd = w_hi;
    assign w_bad_wr = w_hi | w_mis;
    assign err      = w_err & reset_n;
`else
    // Upper and lane-offset address bits alias onto the memory.
    logic w_unused_adr;
    assign w_unused_adr = ^adr;
    assign w_bad_rd     = 1'b0;
    assign w_bad_wr     = 1'b0;
    assign err          = 1'b0;
`endif

    // Wrap bursts only increment the low log2(N) pointer bits; linear uses all bits.
    always_comb begin
        w_wrap_mask = '1;
        case (bte)
            2'b01:   w_wrap_mask = MEM_ADR_WIDTH'(3);
            2'b10:   w_wrap_mask = MEM_ADR_WIDTH'(7);
            2'b11:   w_wrap_mask = MEM_ADR_WIDTH'(15);
            default: w_wrap_mask = '1;
        endcase
        w_ptr_inc = (r_ptr & ~w_wrap_mask) | ((r_ptr + 1'b1) & w_wrap_mask);
    end

    // Handshake: a beat completes in any cycle where cyc & stb & (ack | err) are high.
    always_comb begin
        w_state_nxt    = r_state;
        w_ptr_nxt      = r_ptr;
        w_err_pend_nxt = r_err_pend;
        w_load         = 1'b0;
        w_ack          = 1'b0;
        w_err          = 1'b0;
        w_wr_en        = 1'b0;
        if (!cyc) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (stb && we) begin
                        if (w_bad_wr) begin
                            w_err = 1'b1;
                        end else begin
                            w_ack   = 1'b1;
                            w_wr_en = 1'b1;
                        end
                    end else if (stb) begin
                        w_ptr_nxt      = w_idx;
                        w_load         = 1'b1;
                        w_err_pend_nxt = w_bad_rd;
                        w_state_nxt    = S_RD_FIRST;
                    end
                end
                S_RD_FIRST: begin
                    if (stb && we) begin
                        w_state_nxt = S_IDLE;
                    end else if (stb && r_err_pend) begin
                        w_err       = 1'b1;
                        w_state_nxt = S_IDLE;
                    end else if (stb) begin
                        w_ack = 1'b1;
                        if (cti == 3'b010) begin
                            w_ptr_nxt   = w_ptr_inc;
                            w_load      = 1'b1;
                            w_state_nxt = S_RD_BURST;
                        end else begin
                            w_state_nxt = S_IDLE;
                        end
                    end
                end
                S_RD_BURST: begin
                    if (stb && we) begin
                        w_state_nxt = S_IDLE;
                    end else if (stb) begin
                        w_ack = 1'b1;
                        if (w_last) begin
                            w_state_nxt = S_IDLE;
                        end else begin
                            w_ptr_nxt = w_ptr_inc;
                            w_load    = 1'b1;
                        end
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= S_IDLE;
            r_ptr      <= '0;
            r_dat      <= '0;
            r_err_pend <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_ptr      <= w_ptr_nxt;
            r_err_pend <= w_err_pend_nxt;
            if (w_load) begin
                r_dat <= r_mem[w_ptr_nxt];
            end
        end
    end

    // Contents are deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            for (int b = 0; b < DATA_BYTES; b++) begin
                if (sel[b]) begin
                    r_mem[w_idx][8*b +: 8] <= dat_ms[8*b +: 8];
                end
            end
        end
    end

    assign ack         = w_ack & reset_n;
    assign dat_sm      = r_dat;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_wb_bram_burst.sv
// Directed bench for wb_bram_burst: classic, byte-lane, burst, stall, reset and termination cases.
module tb_wb_bram_burst;
    logic        clk;
    logic        reset_n;
    logic        cyc;
    logic        stb;
    logic        we;
    logic [31:0] adr;
    logic [3:0]  sel;
    logic [31:0] dat_ms;
    logic [2:0]  cti;
    logic [1:0]  bte;
    logic [31:0] dat_sm;
    logic        ack;
    logic        err;
    logic [1:0]  dbg_state;

    int n_checks = 0;
    int n_errors = 0;

    wb_bram_burst #(.MEM_ADR_WIDTH(11), .DATA_BYTES(4)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .cyc         (cyc),
        .stb         (stb),
        .we          (we),
        .adr         (adr),
        .sel         (sel),
        .dat_ms      (dat_ms),
        .cti         (cti),
        .bte         (bte),
        .dat_sm      (dat_sm),
        .ack         (ack),
        .err         (err),
        .o_dbg_state (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_idle();
        cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = 4'h0; cti = 3'b000; bte = 2'b00;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, input string tag);
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = a; dat_ms = d; sel = s; cti = 3'b000; bte = 2'b00;
        #3;
        chk({tag, "_wack"}, {31'd0, ack}, 32'd1);
        next_cycle();
        bus_idle();
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] exp, input string tag);
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = a; sel = 4'h0; cti = 3'b000; bte = 2'b00;
        #3;
        chk({tag, "_req_ack"}, {31'd0, ack}, 32'd0);
        next_cycle();
        #3;
        chk({tag, "_ack"}, {31'd0, ack}, 32'd1);
        chk({tag, "_err"}, {31'd0, err}, 32'd0);
        chk({tag, "_dat"}, dat_sm, exp);
        next_cycle();
        bus_idle();
    endtask

    task automatic burst_req(input logic [31:0] a, input logic [1:0] b, input string tag);
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = a; sel = 4'hF; cti = 3'b010; bte = b;
        #3;
        chk({tag, "_req_ack"}, {31'd0, ack}, 32'd0);
        next_cycle();
    endtask

    task automatic beat(input logic [2:0] c, input logic [31:0] exp, input string tag);
        cti = c;
        #3;
        chk({tag, "_ack"}, {31'd0, ack}, 32'd1);
        chk({tag, "_dat"}, dat_sm, exp);
        next_cycle();
    endtask

    initial begin
        reset_n = 1'b0;
        bus_idle();
        adr = 32'h0; dat_ms = 32'h0;
        #2;
        chk("rst_ack", {31'd0, ack}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_dat", dat_sm, 32'h0);
        chk("rst_state", {30'd0, dbg_state}, 32'd0);
        next_cycle();
        next_cycle();
        reset_n = 1'b1;
        next_cycle();

        // Full-word write then classic read.
        wr(32'h10, 32'hDEADBEEF, 4'hF, "w10");
        rd(32'h10, 32'hDEADBEEF, "r10");

        // Byte lanes and a sel=0 no-op write.
        wr(32'h20, 32'h11223344, 4'hF, "w20a");
        wr(32'h20, 32'hAABBCCDD, 4'b0101, "w20b");
        rd(32'h20, 32'h11BB33DD, "r20");
        wr(32'h20, 32'h00000000, 4'b0000, "w20z");
        rd(32'h20, 32'h11BB33DD, "r20z");

        // Linear burst crossing the top of memory.
        wr(32'h1FFC, 32'hA00007FF, 4'hF, "pl_7ff");
        wr(32'h0000, 32'hA0000000, 4'hF, "pl_0");
        wr(32'h0004, 32'hA0000001, 4'hF, "pl_1");
        wr(32'h0008, 32'hA0000002, 4'hF, "pl_2");
        burst_req(32'h1FFC, 2'b00, "lin");
        beat(3'b010, 32'hA00007FF, "lin_b1");
        beat(3'b010, 32'hA0000000, "lin_b2");
        beat(3'b010, 32'hA0000001, "lin_b3");
        beat(3'b111, 32'hA0000002, "lin_b4");
        bus_idle();
        #3;
        chk("lin_end_ack", {31'd0, ack}, 32'd0);
        chk("lin_end_state", {30'd0, dbg_state}, 32'd0);
        next_cycle();

        // Wrap-4 burst from word 6 with a two-cycle stb stall.
        wr(32'h10, 32'hB0000004, 4'hF, "pl_4");
        wr(32'h14, 32'hB0000005, 4'hF, "pl_5");
        wr(32'h18, 32'hB0000006, 4'hF, "pl_6");
        wr(32'h1C, 32'hB0000007, 4'hF, "pl_7");
        burst_req(32'h18, 2'b01, "wr4");
        beat(3'b010, 32'hB0000006, "wr4_b1");
        beat(3'b010, 32'hB0000007, "wr4_b2");
        stb = 1'b0;
        #3;
        chk("wr4_stall1_ack", {31'd0, ack}, 32'd0);
        chk("wr4_stall1_state", {30'd0, dbg_state}, 32'd2);
        next_cycle();
        #3;
        chk("wr4_stall2_ack", {31'd0, ack}, 32'd0);
        next_cycle();
        stb = 1'b1;
        beat(3'b010, 32'hB0000004, "wr4_b3");
        beat(3'b111, 32'hB0000005, "wr4_b4");
        bus_idle();
        #3;
        chk("wr4_end_state", {30'd0, dbg_state}, 32'd0);
        next_cycle();

        // Asynchronous reset during beat 2 of an 8-beat burst.
        wr(32'h100, 32'hC0000040, 4'hF, "pl_40");
        wr(32'h104, 32'hC0000041, 4'hF, "pl_41");
        burst_req(32'h100, 2'b00, "rst8");
        beat(3'b010, 32'hC0000040, "rst8_b1");
        cti = 3'b010;
        #2;
        chk("rst8_b2_ack_pre", {31'd0, ack}, 32'd1);
        reset_n = 1'b0;
        #1;
        chk("rst8_ack", {31'd0, ack}, 32'd0);
        chk("rst8_dat", dat_sm, 32'h0);
        chk("rst8_state", {30'd0, dbg_state}, 32'd0);
        next_cycle();
        reset_n = 1'b1;
        bus_idle();
        next_cycle();
        rd(32'h104, 32'hC0000041, "rst8_after");

        // Write arriving mid-burst terminates it and is served from IDLE.
        wr(32'h140, 32'hD0000050, 4'hF, "pl_50");
        wr(32'h144, 32'hD0000051, 4'hF, "pl_51");
        burst_req(32'h140, 2'b00, "term");
        beat(3'b010, 32'hD0000050, "term_b1");
        we = 1'b1; adr = 32'h148; dat_ms = 32'h12345678; sel = 4'hF; cti = 3'b000;
        #3;
        chk("term_wr_noack", {31'd0, ack}, 32'd0);
        next_cycle();
        #3;
        chk("term_idle_state", {30'd0, dbg_state}, 32'd0);
        chk("term_wr_ack", {31'd0, ack}, 32'd1);
        next_cycle();
        bus_idle();
        rd(32'h148, 32'h12345678, "term_rd");

        // cyc dropped while the first read beat is pending.
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h140; cti = 3'b000;
        next_cycle();
        bus_idle();
        #3;
        chk("cycdrop_ack", {31'd0, ack}, 32'd0);
        next_cycle();
        #3;
        chk("cycdrop_state", {30'd0, dbg_state}, 32'd0);
        next_cycle();

        // Address above the memory range.
`ifdef WB_BRAM_BURST_ERR_EN
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h0001_0000; cti = 3'b000;
        #3;
        chk("oor_req_err", {31'd0, err}, 32'd0);
        next_cycle();
        #3;
        chk("oor_err", {31'd0, err}, 32'd1);
        chk("oor_ack", {31'd0, ack}, 32'd0);
        next_cycle();
        bus_idle();
`else
        rd(32'h0001_0000, 32'hA0000000, "alias");
`endif

        next_cycle();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
